// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and helpers for the timing generator and its consumers.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;

  localparam int H_TOTAL     = DEF_H_SYNC + DEF_H_BACK + DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int V_TOTAL     = DEF_V_SYNC + DEF_V_BACK + DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int H_VIS_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int V_VIS_START = DEF_V_SYNC + DEF_V_BACK;

  typedef logic [COUNT_W-1:0] count_t;

  // Compared at int width so a window ending exactly at 1024 cannot overflow.
  function automatic logic in_range(count_t value, int lo, int hi);
    return (int'(value) >= lo) && (int'(value) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// VGA scan bus: raster counts, sync/bright decode and pixel/frame strobes.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   pix_tick;
  count_t hCount;
  count_t vCount;
  logic   hSync;
  logic   vSync;
  logic   bright;
  logic   frame_start;

  modport master (output pix_tick, hCount, vCount, hSync, vSync, bright, frame_start);
  modport slave  (input  pix_tick, hCount, vCount, hSync, vSync, bright, frame_start);

endinterface

// File: rtl/clk_en_div.sv
// Clock-enable divider: tick is high for one clk out of every DIV clks.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_r;

  // Free-running modulo-DIV counter; with DIV=1 it sits at 0 and tick stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= '0;
    end else if (div_r == LAST) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + W'(1);
    end
  end

  assign tick = (div_r == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster/sync generator with per-frame pulse.
// Define VGA_PIPE_ALIGN_EN to delay hSync/vSync/bright by one clk for ROM-latency alignment.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int CLK_DIV   = 4
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT   = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int V_TOT   = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int H_END   = H_START + H_VISIBLE;
  localparam int V_END   = V_START + V_VISIBLE;

  localparam count_t H_LAST = COUNT_W'(H_TOT - 1);
  localparam count_t V_LAST = COUNT_W'(V_TOT - 1);

  logic   pix_tick_s;
  count_t h_r;
  count_t v_r;
  logic   frame_start_r;
  logic   hsync_s;
  logic   vsync_s;
  logic   bright_s;

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .tick (pix_tick_s)
  );

  // Raster counters; frame_start is registered off the wrap condition so it
  // is high exactly in the clk where the counts read (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_r           <= '0;
      v_r           <= '0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pix_tick_s && (h_r == H_LAST) && (v_r == V_LAST);
      if (pix_tick_s) begin
        if (h_r == H_LAST) begin
          h_r <= '0;
          v_r <= (v_r == V_LAST) ? '0 : v_r + COUNT_W'(1);
        end else begin
          h_r <= h_r + COUNT_W'(1);
        end
      end
    end
  end

  assign hsync_s  = !in_range(h_r, 0, H_SYNC);
  assign vsync_s  = !in_range(v_r, 0, V_SYNC);
  assign bright_s = in_range(h_r, H_START, H_END) && in_range(v_r, V_START, V_END);

`ifdef VGA_PIPE_ALIGN_EN
  logic hsync_r;
  logic vsync_r;
  logic bright_r;

  // One-clk delay on the decode so it lines up with registered ROM reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_r  <= 1'b0;
      vsync_r  <= 1'b0;
      bright_r <= 1'b0;
    end else begin
      hsync_r  <= hsync_s;
      vsync_r  <= vsync_s;
      bright_r <= bright_s;
    end
  end

  assign vga.hSync  = hsync_r;
  assign vga.vSync  = vsync_r;
  assign vga.bright = bright_r;
`else
  assign vga.hSync  = hsync_s;
  assign vga.vSync  = vsync_s;
  assign vga.bright = bright_s;
`endif

  assign vga.pix_tick    = pix_tick_s;
  assign vga.hCount      = h_r;
  assign vga.vCount      = v_r;
  assign vga.frame_start = frame_start_r;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Source end of the VGA scan interface. Generates the hCount/vCount raster, bright, and active-low hSync/vSync consumed by every sprite and prompt controller in the display path. Derives the 25 MHz pixel rate from the 100 MHz system clock with an internal clock-enable divider. Emits a per-frame pulse so game logic can update state between frames.

Parameters:
H_SYNC, 96, hSync pulse width in pixels (starts at hCount 0)
H_BACK, 48, horizontal back porch in pixels
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch in pixels
V_SYNC, 2, vSync pulse width in lines (starts at vCount 0)
V_BACK, 33, vertical back porch in lines
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch in lines
CLK_DIV, 4, system clocks per pixel; must be >= 1

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
pix_tick  out  1  one-clk pulse per pixel; counters advance on clk edges where it is high
hCount  out  10  pixel column, 0..H_TOTAL-1
vCount  out  10  line number, 0..V_TOTAL-1
hSync  out  1  active-low horizontal sync
vSync  out  1  active-low vertical sync
bright  out  1  high inside the visible window
frame_start  out  1  one-clk pulse when the raster wraps to (0,0)

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Totals: H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT (800); V_TOTAL = V_SYNC+V_BACK+V_VISIBLE+V_FRONT (525). Both must be <= 1024.
- Divider: counter div runs 0..CLK_DIV-1. pix_tick = (div == CLK_DIV-1), combinational from div. With CLK_DIV=1, pix_tick is constantly 1 outside reset.
- On a clk edge with pix_tick high:
  - If hCount == H_TOTAL-1, hCount becomes 0. In the same edge vCount increments, wrapping V_TOTAL-1 -> 0.
  - Otherwise hCount increments.
- Counters hold on edges where pix_tick is low.
- hSync = 0 iff hCount < H_SYNC.
- vSync = 0 iff vCount < V_SYNC.
- bright = 1 iff hCount is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE) and vCount is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE). With defaults: h 144..783, v 35..514.
- hSync, vSync and bright decode combinationally from the count registers, so they are aligned with hCount/vCount (0-cycle latency).
- frame_start: registered. High for exactly one clk, the clk after the edge on which (hCount,vCount) went from (H_TOTAL-1, V_TOTAL-1) to (0,0). It does not pulse on reset release.
- Reset values: div=0, hCount=0, vCount=0, pix_tick=0 (for CLK_DIV>1), frame_start=0, hSync=0, vSync=0, bright=0.
- Reset asserted mid-frame: all state clears immediately, with no glitch-free requirement on the sync outputs. After release, the first pix_tick occurs CLK_DIV clks later.
- No other inputs; free-running.

Optional Feature:
VGA_PIPE_ALIGN_EN
- Defined: hSync, vSync and bright are each delayed by one clk register stage, which resets to 0/0/0. This matches the 1-cycle ROM read latency of sprite controllers, so they can use counts directly. hCount, vCount and frame_start are unchanged.
- Undefined: all outputs are aligned to the counts as specified above.

Decomposition:
- Package vga_timing_pkg holds:
  - default porch/sync/visible constants
  - derived H_TOTAL, V_TOTAL, H_VIS_START, V_VIS_START
  - COUNT_W=10
- Sub-module clk_en_div (parameter DIV) produces pix_tick and is reusable elsewhere.
- Raster counters and sync decode stay in vga_timing_gen.

Test Plan:
- Reset: hold rst 5 clks, then release -> all outputs at reset values; first pix_tick on the 4th clk after release (CLK_DIV=4); hCount=1 after that edge.
- Pixel rate: run 40 clks -> pix_tick high exactly every 4th clk; hCount advances 10.
- Line boundary: hCount=799, vCount=10, then pix_tick -> hCount=0, vCount=11. hSync low for hCount 0..95 and high at 96.
- Visible window: sweep a full frame -> bright high exactly for h 144..783, v 35..514. Count 640*480=307200 bright pixel ticks.
- Frame wrap: from (799,524) -> (0,0) and frame_start pulses for one clk. Next pulse comes 800*525*4 = 1,680,000 clks later. vSync is low only for vCount 0..1.
- Mid-frame reset at (400,200): asserting rst clears the counts immediately, with no frame_start pulse. With VGA_PIPE_ALIGN_EN, bright/hSync lag the count decode by exactly 1 clk.
